chong_rung_nut: RTL and testbench

//  Multi-channel push-button debouncer. Consumes the ena_db strobe from the enable divider.

---
 rtl/chong_rung_nut_if.sv | 33 +++
 rtl/chong_rung_nut.sv | 173 +++++++++++++++++
 tb/tb_chong_rung_nut.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/chong_rung_nut_if.sv
// Button bus between the board-side driver and the debouncer.
// Ports (signals):
//   ena_db     debounce sample strobe, one ckht cycle wide
//   btn_in     raw asynchronous button inputs
//   btn_lvl    debounced level, 1 = pressed
//   btn_pulse  one-cycle pulse on each accepted press
//   btn_rpt    one-cycle auto-repeat pulse while held
// Modports: master drives strobe/raw buttons, slave is the debouncer.
interface chong_rung_nut_if #(
  parameter int unsigned N_BTN = 4
);
  logic             ena_db;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_lvl;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_rpt;

  modport master (
    output ena_db,
    output btn_in,
    input  btn_lvl,
    input  btn_pulse,
    input  btn_rpt
  );

  modport slave (
    input  ena_db,
    input  btn_in,
    output btn_lvl,
    output btn_pulse,
    output btn_rpt
  );
endinterface

// File: rtl/chong_rung_nut.sv
// Multi-channel push-button debouncer with press pulse and auto-repeat.
// Ports:
//   ckht  in  system clock, rising edge
//   rst   in  synchronous reset, active-high
//   bus   slave modport of chong_rung_nut_if
//         (ena_db, btn_in in; btn_lvl, btn_pulse, btn_rpt out, all registered)
module chong_rung_nut #(
  parameter int unsigned N_BTN    = 4,
  parameter int unsigned DB_CNT   = 4,
  parameter int unsigned HOLD_CNT = 50,
  parameter int unsigned RPT_CNT  = 10,
  parameter bit          ACT_LOW  = 1'b1
) (
  input  logic           ckht,
  input  logic           rst,
  chong_rung_nut_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(DB_CNT + 1);
  localparam int unsigned HC_MAX = (HOLD_CNT > RPT_CNT) ? HOLD_CNT : RPT_CNT;
  localparam int unsigned HC_W   = $clog2(HC_MAX + 1);
  // Raw level of a released button; synchronizers reset to it.
  localparam logic        REL_RAW = ACT_LOW;

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_CHK_ON  = 2'd1,
    S_ON      = 2'd2,
    S_CHK_OFF = 2'd3
  } state_t;

  logic [N_BTN-1:0] lvl_vec;
  logic [N_BTN-1:0] pulse_vec;
  logic [N_BTN-1:0] rpt_vec;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic            sync1_q, sync2_q, s;
    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [HC_W-1:0]  hc_q, hc_d, hc_inc, hc_lim;
    logic            rep_q, rep_d;
    logic            lvl_q, lvl_d;
    logic            pulse_q, pulse_d;
    logic            rpt_q, rpt_d;

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge ckht) begin
      if (rst) begin
        sync1_q <= REL_RAW;
        sync2_q <= REL_RAW;
      end else begin
        sync1_q <= bus.btn_in[i];
        sync2_q <= sync1_q;
      end
    end

    assign s       = ACT_LOW ? ~sync2_q : sync2_q;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign hc_inc  = hc_q + HC_W'(1);
    // hc restarts at 0 on every repeat; rep_q selects first-hold vs repeat interval.
    assign hc_lim  = rep_q ? HC_W'(RPT_CNT) : HC_W'(HOLD_CNT);

    // State, counters and registered outputs.
    always_ff @(posedge ckht) begin
      if (rst) begin
        state_q <= S_OFF;
        cnt_q   <= '0;
        hc_q    <= '0;
        rep_q   <= 1'b0;
        lvl_q   <= 1'b0;
        pulse_q <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hc_q    <= hc_d;
        rep_q   <= rep_d;
        lvl_q   <= lvl_d;
        pulse_q <= pulse_d;
        rpt_q   <= rpt_d;
      end
    end

    // Next-state logic; nothing moves unless ena_db is high.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hc_d    = hc_q;
      rep_d   = rep_q;
      pulse_d = 1'b0;
      rpt_d   = 1'b0;
      if (bus.ena_db) begin
        case (state_q)
          S_OFF: begin
            if (s) begin
              if (DB_CNT == 1) begin
                state_d = S_ON;
                cnt_d   = '0;
                hc_d    = '0;
                rep_d   = 1'b0;
                pulse_d = 1'b1;
              end else begin
                state_d = S_CHK_ON;
                cnt_d   = CNT_W'(1);
              end
            end
          end
          S_CHK_ON: begin
            if (s) begin
              if (cnt_inc == CNT_W'(DB_CNT)) begin
                state_d = S_ON;
                cnt_d   = '0;
                hc_d    = '0;
                rep_d   = 1'b0;
                pulse_d = 1'b1;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              state_d = S_OFF;
              cnt_d   = '0;
            end
          end
          S_ON: begin
            if (s) begin
              if (hc_inc == hc_lim) begin
                rpt_d = 1'b1;
                hc_d  = '0;
                rep_d = 1'b1;
              end else begin
                hc_d = hc_inc;
              end
            end else if (DB_CNT == 1) begin
              state_d = S_OFF;
              cnt_d   = '0;
            end else begin
              state_d = S_CHK_OFF;
              cnt_d   = CNT_W'(1);
            end
          end
          S_CHK_OFF: begin
            if (!s) begin
              if (cnt_inc == CNT_W'(DB_CNT)) begin
                state_d = S_OFF;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              // Release glitch: back to ON with hc untouched so cadence resumes.
              state_d = S_ON;
              cnt_d   = '0;
            end
          end
          default: begin
            state_d = S_OFF;
            cnt_d   = '0;
          end
        endcase
      end
      lvl_d = (state_d == S_ON) || (state_d == S_CHK_OFF);
    end

    assign lvl_vec[i]   = lvl_q;
    assign pulse_vec[i] = pulse_q;
    assign rpt_vec[i]   = rpt_q;
  end

  assign bus.btn_lvl   = lvl_vec;
  assign bus.btn_pulse = pulse_vec;
  assign bus.btn_rpt   = rpt_vec;

endmodule

// File: tb/tb_chong_rung_nut.sv
// Directed bench for chong_rung_nut: DB_CNT=4, HOLD_CNT=5, RPT_CNT=2, active-low buttons,
// ena_db once every 10 cycles unless a scenario holds it high.
module tb_chong_rung_nut;
  localparam int unsigned N = 4;

  logic ckht = 1'b0;
  logic rst  = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [N-1:0] obs_lvl, obs_pulse, obs_rpt, acc_pulse;
  logic [N-1:0] prev_pulse = '0;
  int           wide_cnt  = 0;
  int           clash_cnt = 0;

  chong_rung_nut_if #(.N_BTN(N)) bus ();

  chong_rung_nut #(
    .N_BTN(N), .DB_CNT(4), .HOLD_CNT(5), .RPT_CNT(2), .ACT_LOW(1'b1)
  ) dut (
    .ckht(ckht),
    .rst (rst),
    .bus (bus)
  );

  always #5 ckht = ~ckht;

  // Pulses wider than one cycle, or pulse and repeat together.
  always @(posedge ckht) begin
    prev_pulse <= bus.btn_pulse;
    if (|(prev_pulse & bus.btn_pulse)) wide_cnt <= wide_cnt + 1;
    if (|(bus.btn_pulse & bus.btn_rpt)) clash_cnt <= clash_cnt + 1;
  end

  // One ena_db period: 9 idle cycles, one strobe cycle, sample right after it.
  task automatic tick();
    repeat (9) @(negedge ckht);
    bus.ena_db = 1'b1;
    @(negedge ckht);
    bus.ena_db = 1'b0;
    obs_lvl   = bus.btn_lvl;
    obs_pulse = bus.btn_pulse;
    obs_rpt   = bus.btn_rpt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_in = '1;
    bus.ena_db = 1'b0;
    repeat (3) @(negedge ckht);
    checks++; if (bus.btn_lvl !== 4'b0000) begin errors++; $display("FAIL reset_lvl: got %b want 0000", bus.btn_lvl); end
    checks++; if (bus.btn_pulse !== 4'b0000) begin errors++; $display("FAIL reset_pulse: got %b want 0000", bus.btn_pulse); end
    checks++; if (bus.btn_rpt !== 4'b0000) begin errors++; $display("FAIL reset_rpt: got %b want 0000", bus.btn_rpt); end
    rst = 1'b0;
    tick();
    checks++; if (obs_lvl !== 4'b0000) begin errors++; $display("FAIL idle_lvl: got %b want 0000", obs_lvl); end
  endtask

  task automatic test_clean_press();
    logic [N-1:0] exp;
    bus.btn_in[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k == 4) ? 4'b0001 : 4'b0000;
      checks++; if (obs_pulse !== exp) begin errors++; $display("FAIL press_pulse t%0d: got %b want %b", k, obs_pulse, exp); end
      checks++; if (obs_lvl !== exp) begin errors++; $display("FAIL press_lvl t%0d: got %b want %b", k, obs_lvl, exp); end
    end
    @(negedge ckht);
    checks++; if (bus.btn_pulse !== 4'b0000) begin errors++; $display("FAIL press_pulse_width: got %b want 0000", bus.btn_pulse); end
    bus.btn_in[0] = 1'b1;
    acc_pulse = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      acc_pulse |= obs_pulse;
      exp = (k == 4) ? 4'b0000 : 4'b0001;
      checks++; if (obs_lvl !== exp) begin errors++; $display("FAIL release_lvl t%0d: got %b want %b", k, obs_lvl, exp); end
    end
    checks++; if (acc_pulse !== 4'b0000) begin errors++; $display("FAIL release_pulse: got %b want 0000", acc_pulse); end
  endtask

  task automatic test_bounce();
    logic pat [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] exp;
    for (int k = 0; k < 6; k++) begin
      bus.btn_in[1] = pat[k];
      tick();
      exp = (k == 5) ? 4'b0010 : 4'b0000;
      checks++; if (obs_pulse !== exp) begin errors++; $display("FAIL bounce_pulse t%0d: got %b want %b", k, obs_pulse, exp); end
    end
    bus.btn_in[1] = 1'b1;
    repeat (4) tick();
    checks++; if (obs_lvl !== 4'b0000) begin errors++; $display("FAIL bounce_release_lvl: got %b want 0000", obs_lvl); end
  endtask

  task automatic test_hold();
    logic [N-1:0] exp;
    bus.btn_in[2] = 1'b0;
    repeat (4) tick();
    checks++; if (obs_pulse !== 4'b0100) begin errors++; $display("FAIL hold_accept_pulse: got %b want 0100", obs_pulse); end
    acc_pulse = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      acc_pulse |= obs_pulse;
      exp = (k >= 5 && (k % 2) == 1) ? 4'b0100 : 4'b0000;
      checks++; if (obs_rpt !== exp) begin errors++; $display("FAIL hold_rpt t%0d: got %b want %b", k, obs_rpt, exp); end
    end
    checks++; if (acc_pulse !== 4'b0000) begin errors++; $display("FAIL hold_pulse: got %b want 0000", acc_pulse); end
    bus.btn_in[2] = 1'b1;
    repeat (4) tick();
    checks++; if (obs_lvl !== 4'b0000) begin errors++; $display("FAIL hold_release_lvl: got %b want 0000", obs_lvl); end
  endtask

  task automatic test_release_glitch();
    logic [N-1:0] exp;
    bus.btn_in[0] = 1'b0;
    repeat (4) tick();
    checks++; if (obs_pulse !== 4'b0001) begin errors++; $display("FAIL glitch_accept_pulse: got %b want 0001", obs_pulse); end
    repeat (2) tick();
    bus.btn_in[0] = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++; if (obs_lvl !== 4'b0001) begin errors++; $display("FAIL glitch_lvl t%0d: got %b want 0001", k, obs_lvl); end
    end
    bus.btn_in[0] = 1'b0;
    acc_pulse = '0;
    tick();
    acc_pulse |= obs_pulse;
    checks++; if (obs_lvl !== 4'b0001) begin errors++; $display("FAIL glitch_return_lvl: got %b want 0001", obs_lvl); end
    for (int j = 1; j <= 5; j++) begin
      tick();
      acc_pulse |= obs_pulse;
      exp = (j == 3 || j == 5) ? 4'b0001 : 4'b0000;
      checks++; if (obs_rpt !== exp) begin errors++; $display("FAIL glitch_rpt t%0d: got %b want %b", j, obs_rpt, exp); end
    end
    checks++; if (acc_pulse !== 4'b0000) begin errors++; $display("FAIL glitch_pulse: got %b want 0000", acc_pulse); end
    bus.btn_in[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k == 4) ? 4'b0000 : 4'b0001;
      checks++; if (obs_lvl !== exp) begin errors++; $display("FAIL glitch_release_lvl t%0d: got %b want %b", k, obs_lvl, exp); end
    end
  endtask

  // ena_db held high: one sample per cycle.
  task automatic test_back_to_back();
    logic [N-1:0] exp_p, exp_r, exp_l;
    bus.btn_in[1] = 1'b0;
    bus.ena_db    = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge ckht);
      exp_p = (k == 6) ? 4'b0010 : 4'b0000;
      exp_r = (k == 11) ? 4'b0010 : 4'b0000;
      exp_l = (k >= 6) ? 4'b0010 : 4'b0000;
      checks++; if (bus.btn_pulse !== exp_p) begin errors++; $display("FAIL b2b_pulse c%0d: got %b want %b", k, bus.btn_pulse, exp_p); end
      checks++; if (bus.btn_rpt !== exp_r) begin errors++; $display("FAIL b2b_rpt c%0d: got %b want %b", k, bus.btn_rpt, exp_r); end
      checks++; if (bus.btn_lvl !== exp_l) begin errors++; $display("FAIL b2b_lvl c%0d: got %b want %b", k, bus.btn_lvl, exp_l); end
    end
    bus.ena_db    = 1'b0;
    bus.btn_in[1] = 1'b1;
    repeat (4) tick();
    checks++; if (obs_lvl !== 4'b0000) begin errors++; $display("FAIL b2b_release_lvl: got %b want 0000", obs_lvl); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] exp;
    bus.btn_in[0] = 1'b0;
    repeat (4) tick();
    checks++; if (obs_lvl !== 4'b0001) begin errors++; $display("FAIL rmid_pre_lvl: got %b want 0001", obs_lvl); end
    bus.btn_in[3] = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    @(negedge ckht);
    rst = 1'b0;
    checks++; if (bus.btn_lvl !== 4'b0000) begin errors++; $display("FAIL rmid_lvl: got %b want 0000", bus.btn_lvl); end
    checks++; if (bus.btn_pulse !== 4'b0000) begin errors++; $display("FAIL rmid_pulse: got %b want 0000", bus.btn_pulse); end
    checks++; if (bus.btn_rpt !== 4'b0000) begin errors++; $display("FAIL rmid_rpt: got %b want 0000", bus.btn_rpt); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp = (k == 4) ? 4'b1001 : 4'b0000;
      checks++; if (obs_pulse !== exp) begin errors++; $display("FAIL rmid_pulse t%0d: got %b want %b", k, obs_pulse, exp); end
      checks++; if (obs_lvl !== exp) begin errors++; $display("FAIL rmid_lvl t%0d: got %b want %b", k, obs_lvl, exp); end
    end
    bus.btn_in[0] = 1'b1;
    bus.btn_in[3] = 1'b1;
    repeat (4) tick();
    checks++; if (obs_lvl !== 4'b0000) begin errors++; $display("FAIL rmid_release_lvl: got %b want 0000", obs_lvl); end
  endtask

  task automatic test_simultaneous();
    bus.btn_in = 4'b0000;
    repeat (3) tick();
    checks++; if (obs_pulse !== 4'b0000) begin errors++; $display("FAIL sim_early_pulse: got %b want 0000", obs_pulse); end
    tick();
    checks++; if (obs_pulse !== 4'b1111) begin errors++; $display("FAIL sim_pulse: got %b want 1111", obs_pulse); end
    @(negedge ckht);
    checks++; if (bus.btn_pulse !== 4'b0000) begin errors++; $display("FAIL sim_pulse_width: got %b want 0000", bus.btn_pulse); end
    checks++; if (bus.btn_lvl !== 4'b1111) begin errors++; $display("FAIL sim_lvl: got %b want 1111", bus.btn_lvl); end
    bus.btn_in = 4'b1111;
    repeat (4) tick();
    checks++; if (obs_lvl !== 4'b0000) begin errors++; $display("FAIL sim_release_lvl: got %b want 0000", obs_lvl); end
  endtask

  task automatic test_invariants();
    @(negedge ckht);
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL pulse_width_events: got %0d want 0", wide_cnt); end
    checks++; if (clash_cnt !== 0) begin errors++; $display("FAIL pulse_rpt_overlap: got %0d want 0", clash_cnt); end
  endtask

  initial begin
    bus.btn_in = '1;
    bus.ena_db = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold();
    test_release_glitch();
    test_back_to_back();
    test_reset_mid();
    test_simultaneous();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
